// File: rtl/rx_fifo_stream.sv
`default_nettype none
// ============================================================================
//  Module   : rx_fifo_stream
//  Purpose  : Read-side adapter for the RX block-RAM FIFO (registered output,
//             no first-word fall-through). Issues credit-limited reads, absorbs
//             the fixed read latency in a small skid buffer and presents the
//             words as a valid/ready stream master.
//  Revision : 1.0 - initial release
// ============================================================================
module rx_fifo_stream #(
  parameter int READ_LATENCY = 2,
  parameter int BUF_DEPTH    = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              i_fifo_empty,
  output logic                              o_fifo_re,
  input  logic [31:0]                       i_fifo_dout,
  output logic [31:0]                       o_m_tdata,
  output logic                              o_m_tvalid,
  input  logic                              i_m_tready,
  output logic [$clog2(READ_LATENCY+1)-1:0] o_in_flight,
  output logic [31:0]                       o_rx_words
);

  // Widths: pointers index the buffer, occupancy must reach BUF_DEPTH itself,
  // the in-flight counter must reach READ_LATENCY itself.
  localparam int c_PTR_W = $clog2(BUF_DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;
  localparam int c_FLT_W = $clog2(READ_LATENCY + 1);

  localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
  localparam logic [c_FLT_W-1:0] c_FLT_ONE = c_FLT_W'(1);
  localparam logic [31:0]        c_WRD_ONE = 32'd1;

  logic [READ_LATENCY-1:0] r_rd_pipe;
  logic [31:0]             r_buf [BUF_DEPTH];
  logic [c_PTR_W-1:0]      r_wr_ptr;
  logic [c_PTR_W-1:0]      r_rd_ptr;
  logic [c_CNT_W-1:0]      r_count;
  logic [c_FLT_W-1:0]      r_in_flight;
  logic [31:0]             r_rx_words;

  logic                    w_capture;
  logic                    w_pop;
  logic                    w_credit;
  logic                    w_re;

  // A read issued READ_LATENCY cycles ago has its word on i_fifo_dout now.
  assign w_capture = r_rd_pipe[READ_LATENCY-1];

  // Credit counts buffered words plus reads still in the pipe, both taken
  // from registers; a same-cycle pop is deliberately not credited so the
  // buffer can never overflow.
  assign w_credit  = (32'(r_count) + 32'(r_in_flight)) < 32'(BUF_DEPTH);
  assign w_re      = !rst && !i_fifo_empty && w_credit;
  assign o_fifo_re = w_re;

  assign o_m_tvalid  = (r_count != '0);
  assign o_m_tdata   = r_buf[r_rd_ptr];
  assign w_pop       = o_m_tvalid && i_m_tready;
  assign o_in_flight = r_in_flight;
  assign o_rx_words  = r_rx_words;

  // Read-latency tracking shift register; a single stage needs no shift.
  generate
    if (READ_LATENCY == 1) begin : g_pipe_single
      // Track the one outstanding read stage.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_rd_pipe <= '0;
        end else begin
          r_rd_pipe <= w_re;
        end
      end
    end else begin : g_pipe_multi
      // Shift the read enable toward the capture stage.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_rd_pipe <= '0;
        end else begin
          r_rd_pipe <= {r_rd_pipe[READ_LATENCY-2:0], w_re};
        end
      end
    end
  endgenerate

  // Capture returning FIFO data into the skid buffer; entries clear on reset
  // so the stream data output starts at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        r_buf[i] <= '0;
      end
      r_wr_ptr <= '0;
    end else if (w_capture) begin
      r_buf[r_wr_ptr] <= i_fifo_dout;
      r_wr_ptr        <= r_wr_ptr + c_PTR_ONE;
    end
  end

  // Advance the read pointer and the handshake counter on every transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr   <= '0;
      r_rx_words <= '0;
    end else if (w_pop) begin
      r_rd_ptr   <= r_rd_ptr + c_PTR_ONE;
      r_rx_words <= r_rx_words + c_WRD_ONE;
    end
  end

  // Buffer occupancy: capture adds, handshake removes, both cancel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else begin
      case ({w_capture, w_pop})
        2'b10:   r_count <= r_count + c_CNT_ONE;
        2'b01:   r_count <= r_count - c_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Outstanding reads: issue adds, capture removes, both cancel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_in_flight <= '0;
    end else begin
      case ({w_re, w_capture})
        2'b10:   r_in_flight <= r_in_flight + c_FLT_ONE;
        2'b01:   r_in_flight <= r_in_flight - c_FLT_ONE;
        default: r_in_flight <= r_in_flight;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rx_fifo_stream.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rx_fifo_stream
//  Purpose  : Scoreboard bench for rx_fifo_stream with a behavioural
//             two-cycle-latency FIFO model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rx_fifo_stream;

  logic        clk;
  logic        rst;
  logic        fifo_empty;
  logic        fifo_re;
  logic [31:0] fifo_dout;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tready;
  logic [1:0]  in_flight;
  logic [31:0] rx_words;

  int          n_cmp;
  int          n_err;
  logic [31:0] fq[$];
  logic [31:0] exp_q[$];
  logic [31:0] p1;
  logic [31:0] m_cnt;
  logic        stall;
  logic [31:0] stall_data;

  rx_fifo_stream #(.READ_LATENCY(2), .BUF_DEPTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_fifo_empty(fifo_empty),
    .o_fifo_re   (fifo_re),
    .i_fifo_dout (fifo_dout),
    .o_m_tdata   (tdata),
    .o_m_tvalid  (tvalid),
    .i_m_tready  (tready),
    .o_in_flight (in_flight),
    .o_rx_words  (rx_words)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, req);
    end
  endtask

  task automatic push(input logic [31:0] w);
    fq.push_back(w);
    exp_q.push_back(w);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int limit, input string name);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < limit) begin
      @(posedge clk);
      k++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_timeout: %0d words pending, required 0", name, exp_q.size());
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  // FIFO model: registered empty flag, two-cycle registered read path.
  initial begin
    fifo_empty = 1'b1;
    fifo_dout  = '0;
    p1         = '0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        fq.delete();
        p1         <= '0;
        fifo_dout  <= '0;
        fifo_empty <= 1'b1;
      end else begin
        if (fifo_re && fq.size() > 0) p1 <= fq.pop_front();
        fifo_dout  <= p1;
        fifo_empty <= (fq.size() == 0);
      end
    end
  end

  // Monitor: pops the scoreboard on every handshake and checks stream rules.
  initial begin
    stall      = 1'b0;
    stall_data = '0;
    m_cnt      = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall = 1'b0;
        m_cnt = '0;
        continue;
      end
      chk("re_while_empty", {31'd0, fifo_re && fifo_empty}, 32'd0);
      chk("overflow", {31'd0, dut.r_count > 3'd4}, 32'd0);
      if (stall) begin
        chk("stall_valid", {31'd0, tvalid}, 32'd1);
        chk("stall_data", tdata, stall_data);
      end
      if (tvalid && tready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_word: got 0x%08h required none", tdata);
        end else begin
          chk("stream_data", tdata, exp_q.pop_front());
          chk("rx_words_seq", rx_words, m_cnt);
          m_cnt = m_cnt + 32'd1;
        end
      end
      stall      = tvalid && !tready;
      stall_data = tdata;
    end
  end

  initial begin
    logic [7:0] re_mask;
    logic [7:0] vld_mask;
    int         cnt;
    int         first;
    int         last;
    int         k;

    n_cmp  = 0;
    n_err  = 0;
    rst    = 1'b1;
    tready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_fifo_re", {31'd0, fifo_re}, 32'd0);
    chk("rst_tvalid", {31'd0, tvalid}, 32'd0);
    chk("rst_tdata", tdata, 32'd0);
    chk("rst_in_flight", {30'd0, in_flight}, 32'd0);
    chk("rst_rx_words", rx_words, 32'd0);
    step();
    rst = 1'b0;
    step();

    // Single word: read issued one cycle after the push, valid three later.
    tready = 1'b1;
    push(32'hDEADBEEF);
    re_mask  = '0;
    vld_mask = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      re_mask[i]  = fifo_re;
      vld_mask[i] = tvalid;
    end
    chk("single_re_timing", {24'd0, re_mask}, 32'h02);
    chk("single_valid_timing", {24'd0, vld_mask}, 32'h10);
    step();
    chk("single_rx_words", rx_words, 32'd1);

    // Streaming: 16 words, consecutive valid cycles.
    for (int i = 0; i < 16; i++) push(i);
    cnt = 0; first = -1; last = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (tvalid) begin
        cnt++;
        if (first < 0) first = i;
        last = i;
      end
    end
    chk("stream_valid_count", cnt, 32'd16);
    chk("stream_contiguous", last - first + 1, 32'd16);
    drain(50, "stream");
    chk("stream_rx_words", rx_words, 32'd17);

    // Backpressure: only BUF_DEPTH reads before the credit runs out.
    tready = 1'b0;
    for (int i = 0; i < 10; i++) push(32'hB000_0000 + i);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (fifo_re) cnt++;
    end
    chk("bp_re_pulses", cnt, 32'd4);
    chk("bp_count", {29'd0, dut.r_count}, 32'd4);
    chk("bp_tdata", tdata, 32'hB000_0000);
    step();
    tready = 1'b1;
    drain(100, "bp");
    chk("bp_rx_words", rx_words, 32'd27);

    // Random ready, 100 words.
    for (int i = 0; i < 100; i++) push(32'h5A00_0000 + (i * 32'h0101));
    k = 0;
    while (exp_q.size() != 0 && k < 2000) begin
      tready = 1'($urandom_range(0, 1));
      step();
      k++;
    end
    tready = 1'b1;
    drain(100, "random");
    chk("random_rx_words", rx_words, 32'd127);

    // Reset mid-stream with two reads in flight and two words buffered.
    tready = 1'b0;
    for (int i = 0; i < 10; i++) push(32'hC000_0000 + i);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(in_flight == 2'd2 && dut.r_count == 3'd2) && k < 50);
    chk("rstmid_reached", {31'd0, in_flight == 2'd2 && dut.r_count == 3'd2}, 32'd1);
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("rstmid_fifo_re", {31'd0, fifo_re}, 32'd0);
    chk("rstmid_tvalid", {31'd0, tvalid}, 32'd0);
    chk("rstmid_tdata", tdata, 32'd0);
    chk("rstmid_in_flight", {30'd0, in_flight}, 32'd0);
    chk("rstmid_rx_words", rx_words, 32'd0);
    repeat (2) step();
    rst = 1'b0;
    step();
    tready = 1'b1;
    for (int i = 0; i < 5; i++) push(32'hE000_0000 + i);
    drain(50, "rstmid");
    chk("rstmid_post_words", rx_words, 32'd5);

    // Counter wrap.
    force dut.r_rx_words = 32'hFFFF_FFFE;
    m_cnt = 32'hFFFF_FFFE;
    @(negedge clk);
    release dut.r_rx_words;
    step();
    for (int i = 0; i < 3; i++) push(32'hF000_0000 + i);
    drain(50, "wrap");
    chk("wrap_rx_words", rx_words, 32'h0000_0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
